// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC vectoring core.
// Angles are Q2.14 radians (2^14 = 1 rad).
package cordic_pkg;

    localparam int ANGLE_FRAC  = 14;
    localparam int PI          = 51472;
    localparam int PI_2        = 25736;
    localparam int CORDIC_GAIN = 26981;
    localparam int ATAN_DEPTH  = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/atan_table.sv
// Arctangent lookup: step i -> round(atan(2^-i) * 2^14).
// Indices past the table depth return zero.
module atan_table
    import cordic_pkg::*;
#(
    parameter int AW = 4,
    parameter int ZW = 18
) (
    input  logic [AW-1:0]        step,
    output logic signed [ZW-1:0] value
);

    always_comb begin
        value = '0;
        case (int'(step))
            0:       value = ZW'(12868);
            1:       value = ZW'(7596);
            2:       value = ZW'(4014);
            3:       value = ZW'(2037);
            4:       value = ZW'(1023);
            5:       value = ZW'(512);
            6:       value = ZW'(256);
            7:       value = ZW'(128);
            8:       value = ZW'(64);
            9:       value = ZW'(32);
            10:      value = ZW'(16);
            11:      value = ZW'(8);
            12:      value = ZW'(4);
            13:      value = ZW'(2);
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: one micro-rotation per clock, returns
// atan2(y,x) in Q2.14 radians and the gain-scaled magnitude.
module cordic_vectoring_iter
    import cordic_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int STEPS = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [BITS:0] x_in,
    input  logic signed [BITS:0] y_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [BITS:0] angle,
    output logic [BITS+1:0]      magnitude
);

    localparam int XW = BITS + 3;
    localparam int ZW = BITS + 2;
    localparam int CW = $clog2(STEPS);

    state_t                 state_reg;
    logic signed [XW-1:0]   x_reg;
    logic signed [XW-1:0]   y_reg;
    logic signed [ZW-1:0]   z_reg;
    logic [CW-1:0]          iter_reg;
    logic                   zero_reg;
    logic                   out_valid_reg;
    logic signed [BITS:0]   angle_reg;
    logic [BITS+1:0]        mag_reg;

    logic signed [XW-1:0]   x_ext;
    logic signed [XW-1:0]   y_ext;
    logic signed [XW-1:0]   x_pre;
    logic signed [XW-1:0]   y_pre;
    logic signed [ZW-1:0]   z_pre;
    logic signed [XW-1:0]   x_sh;
    logic signed [XW-1:0]   y_sh;
    logic signed [ZW-1:0]   atan_val;

    assign x_ext = {{2{x_in[BITS]}}, x_in};
    assign y_ext = {{2{y_in[BITS]}}, y_in};

    // Fold left-half-plane vectors by +-90 degrees so the iterations only
    // have to cover |phase| <= pi/2.
    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = '0;
        if (x_in[BITS]) begin
            if (!y_in[BITS]) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = ZW'(PI_2);
            end else begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = ZW'(-PI_2);
            end
        end
    end

    assign x_sh = x_reg >>> iter_reg;
    assign y_sh = y_reg >>> iter_reg;

    atan_table #(
        .AW (CW),
        .ZW (ZW)
    ) u_atan_table (
        .step  (iter_reg),
        .value (atan_val)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            z_reg         <= '0;
            iter_reg      <= '0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            angle_reg     <= '0;
            mag_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= x_pre;
                        y_reg     <= y_pre;
                        z_reg     <= z_pre;
                        iter_reg  <= '0;
                        zero_reg  <= (x_in == '0) && (y_in == '0);
                        state_reg <= ITER;
                    end
                end
                ITER: begin
                    // Drive y toward zero; z accumulates the rotation applied.
                    if (!y_reg[XW-1]) begin
                        x_reg <= x_reg + y_sh;
                        y_reg <= y_reg - x_sh;
                        z_reg <= z_reg + atan_val;
                    end else begin
                        x_reg <= x_reg - y_sh;
                        y_reg <= y_reg + x_sh;
                        z_reg <= z_reg - atan_val;
                    end
                    iter_reg <= iter_reg + 1'b1;
                    if (iter_reg == CW'(STEPS - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid_reg) begin
                        angle_reg     <= zero_reg ? '0 : z_reg[BITS:0];
                        mag_reg       <= x_reg[BITS+1:0];
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign angle     = angle_reg;
    assign magnitude = mag_reg;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Randomised and directed checks of the vectoring CORDIC against a real-valued
// atan2/hypot reference, plus literal expectations for the canonical vectors.
`timescale 1ns/1ps
module tb_cordic_vectoring_iter;

    localparam int BITS   = 16;
    localparam int STEPS  = 14;
    localparam int PI_Q   = 51472;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [BITS:0] x_in = '0;
    logic signed [BITS:0] y_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [BITS:0] angle;
    logic [BITS+1:0]      magnitude;

    cordic_vectoring_iter #(.BITS(BITS), .STEPS(STEPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .angle     (angle),
        .magnitude (magnitude)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  x;
        int  y;
        int  exp_angle;
        int  angle_tol;
        real exp_mag;
        real mag_tol;
        int  acc_cycle;
        bit  has_lit;
        int  lit_angle;
        int  lit_atol;
        int  lit_mag;
        int  lit_mtol;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    passes = 0;
    int    cyc = 0;
    int    ready_mode = 0;
    real   gain = 1.0;

    bit    lit_en = 1'b0;
    int    lit_angle = 0, lit_atol = 0, lit_mag = 0, lit_mtol = 0;

    bit    busy = 1'b0;
    bit    prev_valid = 1'b0;
    int    last_angle = 0;
    int    last_mag = 0;

    task automatic check(input bit ok, input string nm, input int act, input int req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    function automatic int adiff(input int a, input int b);
        int d;
        d = a - b;
        if (d > PI_Q) d -= 2 * PI_Q;
        if (d < -PI_Q) d += 2 * PI_Q;
        return (d < 0) ? -d : d;
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // True atan2 in Q2.14 and |v|*K with K = prod sqrt(1 + 2^-2i).
    task automatic model(input int x, input int y, output int a, output real m);
        if (x == 0 && y == 0) begin
            a = 0;
            m = 0.0;
        end else begin
            a = int'($atan2(real'(y), real'(x)) * 16384.0);
            m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * gain;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'b0;
        else out_ready = 1'($urandom_range(0, 1));
    end

    // Compare process: every cycle checks handshake state, result values,
    // latency, stall stability and output hold.
    always @(negedge clk) begin
        item_t it;
        item_t nit;
        if (!rst_n) begin
            exp_q.delete();
            busy       = 1'b0;
            prev_valid = 1'b0;
            last_angle = 0;
            last_mag   = 0;
        end else begin
            check(in_ready == !busy, "in_ready", int'(in_ready), int'(!busy));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "spurious_out_valid", 1, 0);
                end else if (!prev_valid) begin
                    it = exp_q[0];
                    check(cyc - it.acc_cycle == STEPS + 1, "latency", cyc - it.acc_cycle, STEPS + 1);
                    check(adiff(int'(angle), it.exp_angle) <= it.angle_tol, "angle_vs_model",
                          int'(angle), it.exp_angle);
                    check(rabs(real'(magnitude) - it.exp_mag) <= it.mag_tol, "mag_vs_model",
                          int'(magnitude), $rtoi(it.exp_mag));
                    if (it.has_lit) begin
                        check(adiff(int'(angle), it.lit_angle) <= it.lit_atol, "angle_literal",
                              int'(angle), it.lit_angle);
                        check(rabs(real'(magnitude) - real'(it.lit_mag)) <= real'(it.lit_mtol),
                              "mag_literal", int'(magnitude), it.lit_mag);
                    end
                    last_angle = int'(angle);
                    last_mag   = int'(magnitude);
                    $display("txn x=%0d y=%0d angle=%0d (ref %0d) mag=%0d (ref %0d)",
                             it.x, it.y, int'(angle), it.exp_angle, int'(magnitude), $rtoi(it.exp_mag));
                end else begin
                    check(int'(angle) == last_angle, "stall_angle", int'(angle), last_angle);
                    check(int'(magnitude) == last_mag, "stall_mag", int'(magnitude), last_mag);
                end
                if (out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    busy = 1'b0;
                end
                prev_valid = !out_ready;
            end else begin
                check(int'(angle) == last_angle, "hold_angle", int'(angle), last_angle);
                check(int'(magnitude) == last_mag, "hold_mag", int'(magnitude), last_mag);
                prev_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                nit.x = int'(x_in);
                nit.y = int'(y_in);
                model(nit.x, nit.y, nit.exp_angle, nit.exp_mag);
                if (nit.x == 0 && nit.y == 0) begin
                    nit.angle_tol = 0;
                    nit.mag_tol   = 2.0;
                end else begin
                    nit.angle_tol = 8;
                    nit.mag_tol   = nit.exp_mag * 0.001 + 8.0;
                end
                nit.acc_cycle = cyc + 1;
                nit.has_lit   = lit_en;
                nit.lit_angle = lit_angle;
                nit.lit_atol  = lit_atol;
                nit.lit_mag   = lit_mag;
                nit.lit_mtol  = lit_mtol;
                exp_q.push_back(nit);
                busy = 1'b1;
            end
        end
    end

    task automatic send(input int x, input int y);
        int n;
        n = 0;
        x_in     = (BITS+1)'(x);
        y_in     = (BITS+1)'(y);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(1'b0, "accept_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_lit(input int x, input int y, input int la, input int lat,
                            input int lm, input int lmt);
        lit_en    = 1'b1;
        lit_angle = la;
        lit_atol  = lat;
        lit_mag   = lm;
        lit_mtol  = lmt;
        send(x, y);
        lit_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check(1'b0, "idle_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int x, y, n;
        real r;
        r = 1.0;
        for (int i = 0; i < STEPS; i++) begin
            gain = gain * $sqrt(1.0 + r);
            r = r / 4.0;
        end

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Canonical vectors with hand-computed expectations.
        send_lit(16384, 0, 0, 8, 26981, 27);
        wait_idle();
        send_lit(0, 16384, 25736, 8, 26981, 27);
        wait_idle();
        send_lit(-16384, 0, 51472, 8, 26981, 27);
        wait_idle();
        send_lit(-16384, -16384, -38604, 8, 38156, 38);
        wait_idle();
        send_lit(0, 0, 0, 0, 0, 2);
        wait_idle();

        // Extremes of the input range.
        send(-65536, -65536);
        send(65535, 65535);
        send(-65536, 0);
        send(0, -65536);
        send(-65536, 1);
        send(30000, -1);
        wait_idle();

        // Stall the result for more than 5 cycles, then back-to-back vectors.
        ready_mode = 1;
        send(12000, -9000);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check(1'b0, "out_valid_timeout", n, 0);
        repeat (5) @(posedge clk);
        ready_mode = 0;
        send(-20000, 7000);
        send(5000, 25000);
        send(-30000, -2000);
        wait_idle();

        // Abort mid-iteration with a one-cycle reset.
        send(20000, 5000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(-9000, 23000);
        wait_idle();

        // Random vectors with random backpressure.
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            do begin
                x = int'($urandom_range(0, 131071)) - 65536;
                y = int'($urandom_range(0, 131071)) - 65536;
            end while (real'(x) * real'(x) + real'(y) * real'(y) < 24576.0 * 24576.0);
            send(x, y);
        end
        ready_mode = 0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", checks);
        $fatal(1, "watchdog");
    end

endmodule
